// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-tick debounce and a valid/ack holding register for the processor.
// Rows are synchronized through two flops; every output is registered.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] column,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       overrun
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_N     = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_n;
  logic [3:0]    row_m, row_s;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx, col_n;
  logic [3:0]    cand, cand_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    rcnt, rcnt_n;
  logic          tick, any_low, accept;
  logic [1:0]    row_idx;
  logic [3:0]    acc_code;
  logic          vld_n, ovr_n;
  logic [3:0]    code_n;

  assign tick    = (div_cnt == DIV_LAST);
  assign any_low = ~&row_s;

  // Lowest-numbered low row wins when several keys share the driven column.
  always_comb begin
    row_idx = 2'd3;
    if (!row_s[0])      row_idx = 2'd0;
    else if (!row_s[1]) row_idx = 2'd1;
    else if (!row_s[2]) row_idx = 2'd2;
  end

  always_comb begin
    state_n  = state;
    col_n    = col_idx;
    cand_n   = cand;
    cnt_n    = cnt;
    rcnt_n   = rcnt;
    accept   = 1'b0;
    acc_code = cand;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_n   = {row_idx, col_idx};
            acc_code = {row_idx, col_idx};
            cnt_n    = 4'd1;
            if (DB_N == 4'd1) begin
              accept  = 1'b1;
              state_n = HELD;
              rcnt_n  = 4'd0;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low && (row_idx == cand[3:2])) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DB_N) begin
              accept  = 1'b1;
              state_n = HELD;
              rcnt_n  = 4'd0;
            end
          end else begin
            state_n = SCAN;
            col_n   = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (!any_low) begin
            rcnt_n = rcnt + 4'd1;
            if (rcnt + 4'd1 == DB_N) begin
              state_n = SCAN;
              rcnt_n  = 4'd0;
              col_n   = col_idx + 2'd1;
            end
          end else begin
            rcnt_n = 4'd0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // An accept coinciding with key_ack loads the new key and clears overrun.
  always_comb begin
    vld_n  = key_valid;
    code_n = key_code;
    ovr_n  = overrun;
    if (accept) begin
      if (key_valid && !key_ack) begin
        ovr_n = 1'b1;
      end else begin
        vld_n  = 1'b1;
        code_n = acc_code;
        if (key_ack) ovr_n = 1'b0;
      end
    end else if (key_ack && key_valid) begin
      vld_n = 1'b0;
      ovr_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      row_m     <= 4'hF;
      row_s     <= 4'hF;
      div_cnt   <= '0;
      col_idx   <= 2'd0;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      rcnt      <= 4'd0;
      column    <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      row_m     <= row;
      row_s     <= row_m;
      div_cnt   <= tick ? '0 : div_cnt + DW'(1);
      col_idx   <= col_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      column    <= ~(4'b0001 << col_n);
      key_valid <= vld_n;
      key_code  <= code_n;
      key_held  <= (state_n == HELD);
      overrun   <= ovr_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: timed vector table, directed corner sequences, randomized press sessions.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_ack = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  row;
  logic [3:0]  column;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        overrun;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  int          onehot_bad = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .key_ack(key_ack),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !column[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  always @(negedge clk)
    if (rst && $countones(column) != 3) onehot_bad <= onehot_bad + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          cyc;
    logic [15:0] keys;
    logic        ack;
    logic [3:0]  col;
    logic        vld;
    logic [3:0]  code;
    logic        held;
    logic        ovr;
  } vec_t;

  vec_t vec[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic wait_held(input logic lvl, input string name);
    int g = 0;
    while (key_held !== lvl && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) timeout(name);
  endtask

  task automatic press_key(input logic [15:0] k, input string name);
    keys = k;
    wait_held(1'b1, name);
  endtask

  task automatic release_keys(input string name);
    keys = 16'h0;
    wait_held(1'b0, name);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // Reference rule: the reported code is {row, column} of the lowest pressed row in the scanned column.
  function automatic logic [3:0] model_code(input int r, input int c);
    return 4'(r * 4 + c);
  endfunction

  initial begin
    vec[0]  = '{1,  16'h0000, 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[1]  = '{3,  16'h0000, 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[2]  = '{4,  16'h0000, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[3]  = '{7,  16'h0000, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[4]  = '{8,  16'h0000, 1'b0, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[5]  = '{12, 16'h0000, 1'b0, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[6]  = '{15, 16'h0000, 1'b0, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[7]  = '{16, 16'h0200, 1'b0, 4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[8]  = '{20, 16'h0200, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[9]  = '{24, 16'h0200, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[10] = '{27, 16'h0200, 1'b0, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
    vec[11] = '{28, 16'h0200, 1'b0, 4'hD, 1'b1, 4'h9, 1'b1, 1'b0};
    vec[12] = '{30, 16'h0200, 1'b1, 4'hD, 1'b1, 4'h9, 1'b1, 1'b0};
    vec[13] = '{31, 16'h0000, 1'b0, 4'hD, 1'b0, 4'h9, 1'b1, 1'b0};
    vec[14] = '{39, 16'h0000, 1'b0, 4'hD, 1'b0, 4'h9, 1'b1, 1'b0};
    vec[15] = '{40, 16'h0000, 1'b0, 4'hB, 1'b0, 4'h9, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_column", 16'(column), 16'hE);
    check("reset_valid", 16'(key_valid), 16'h0);
    check("reset_code", 16'(key_code), 16'h0);
    check("reset_held", 16'(key_held), 16'h0);
    check("reset_overrun", 16'(overrun), 16'h0);
    rst = 1'b1;

    // Idle rotation, then press/ack/release of row 2 col 1.
    for (int e = 0; e < 16; e++) begin
      int g = 0;
      while (cyc != vec[e].cyc && g < 100) begin
        @(negedge clk);
        key_ack = 1'b0;
        g++;
      end
      if (g >= 100) timeout("vec_wait");
      check($sformatf("vec%0d_column", e), 16'(column), 16'(vec[e].col));
      check($sformatf("vec%0d_valid", e), 16'(key_valid), 16'(vec[e].vld));
      check($sformatf("vec%0d_code", e), 16'(key_code), 16'(vec[e].code));
      check($sformatf("vec%0d_held", e), 16'(key_held), 16'(vec[e].held));
      check($sformatf("vec%0d_overrun", e), 16'(overrun), 16'(vec[e].ovr));
      keys    = vec[e].keys;
      key_ack = vec[e].ack;
    end

    // Bounce: row 0 col 3 seen for a single tick only.
    begin
      int g = 0;
      @(negedge clk);
      key_ack = 1'b0;
      while (column !== 4'h7 && g < 64) begin
        @(negedge clk);
        g++;
      end
      if (g >= 64) timeout("bounce_wait_col3");
      keys = 16'h0008;
      repeat (3) @(negedge clk);
      keys = 16'h0000;
      @(negedge clk);
      check("bounce_frozen", 16'(column), 16'h7);
      repeat (3) @(negedge clk);
      check("bounce_still_frozen", 16'(column), 16'h7);
      @(negedge clk);
      check("bounce_advance", 16'(column), 16'hE);
      check("bounce_valid", 16'(key_valid), 16'h0);
      check("bounce_held", 16'(key_held), 16'h0);
    end

    // Overrun: second key dropped while the first is unconsumed.
    press_key(16'h0020, "ovr_press_a");
    check("ovr_a_valid", 16'(key_valid), 16'h1);
    check("ovr_a_code", 16'(key_code), 16'h5);
    check("ovr_a_flag", 16'(overrun), 16'h0);
    release_keys("ovr_release_a");
    press_key(16'h0400, "ovr_press_b");
    check("ovr_b_valid", 16'(key_valid), 16'h1);
    check("ovr_b_code", 16'(key_code), 16'h5);
    check("ovr_b_flag", 16'(overrun), 16'h1);
    release_keys("ovr_release_b");
    pulse_ack();
    check("ovr_ack_valid", 16'(key_valid), 16'h0);
    check("ovr_ack_flag", 16'(overrun), 16'h0);
    check("ovr_ack_code", 16'(key_code), 16'h5);

    // Ack on the exact cycle of the next accept.
    press_key(16'h0020, "coll_press_a");
    release_keys("coll_release_a");
    press_key(16'h0040, "coll_press_b");
    release_keys("coll_release_b");
    check("coll_pre_overrun", 16'(overrun), 16'h1);
    begin
      int g = 0;
      while (!(column === 4'hE && (cyc % 4) == 0) && g < 64) begin
        @(negedge clk);
        g++;
      end
      if (g >= 64) timeout("coll_wait_col0");
      keys = 16'h1000;
      repeat (7) @(negedge clk);
      check("coll_before_valid", 16'(key_valid), 16'h1);
      check("coll_before_code", 16'(key_code), 16'h5);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      check("coll_valid", 16'(key_valid), 16'h1);
      check("coll_code", 16'(key_code), 16'hC);
      check("coll_overrun", 16'(overrun), 16'h0);
      check("coll_held", 16'(key_held), 16'h1);
    end

    // Asynchronous reset while held with rows 0 and 3 low.
    keys = 16'h1001;
    #2 rst = 1'b0;
    #1;
    check("arst_column", 16'(column), 16'hE);
    check("arst_valid", 16'(key_valid), 16'h0);
    check("arst_code", 16'(key_code), 16'h0);
    check("arst_held", 16'(key_held), 16'h0);
    check("arst_overrun", 16'(overrun), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    begin
      int g = 0;
      while (!key_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) timeout("rerun_wait_valid");
      check("rerun_latency", 16'(cyc), 16'd8);
      check("rerun_code", 16'(key_code), 16'(model_code(0, 0)));
      check("rerun_held", 16'(key_held), 16'h1);
    end
    pulse_ack();
    release_keys("rerun_release");

    // Randomized press sessions: one or two keys in one column, ack on every valid.
    for (int s = 0; s < 40; s++) begin
      int nk, c, r1, r2, rlo, accepts;
      logic [15:0] mask;
      logic [3:0] exp_code;
      nk  = $urandom_range(1, 2);
      c   = $urandom_range(0, 3);
      r1  = $urandom_range(0, 3);
      r2  = (r1 + 1 + $urandom_range(0, 2)) % 4;
      mask = 16'h0;
      mask[r1*4+c] = 1'b1;
      rlo = r1;
      if (nk == 2) begin
        mask[r2*4+c] = 1'b1;
        if (r2 < rlo) rlo = r2;
      end
      exp_code = model_code(rlo, c);
      accepts = 0;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      keys = mask;
      for (int t = 0; t < 40 + int'($urandom_range(0, 20)); t++) begin
        @(negedge clk);
        key_ack = 1'b0;
        if (key_valid) begin
          accepts++;
          check("rand_code", 16'(key_code), 16'(exp_code));
          key_ack = 1'b1;
        end
      end
      check("rand_held", 16'(key_held), 16'h1);
      keys = 16'h0;
      for (int t = 0; t < 24 + int'($urandom_range(0, 10)); t++) begin
        @(negedge clk);
        key_ack = 1'b0;
        if (key_valid) begin
          accepts++;
          key_ack = 1'b1;
        end
      end
      check("rand_released", 16'(key_held), 16'h0);
      check("rand_accepts", 16'(accepts), 16'd1);
      check("rand_overrun", 16'(overrun), 16'h0);
    end

    check("column_onehot", 16'(onehot_bad), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
